io_hub_v2: RTL and testbench

- Parametrised memory-mapped I/O hub between the CPU data port and data memory.
- Decodes addr[31:28]==4'hF as I/O space and addr[27:24] as device: seven-segment digits, LEDs, switches, keys.
- New versus the first-generation hub:
  - single-clock synchronous writes;
  - configurable widths;
  - switch synchronisers;
  - per-key debounce;
  - sticky key-press edge capture with maskable interrupt.

---
 rtl/io_hub_pkg.sv | 19 +
 rtl/key_debounce.sv | 47 ++++
 rtl/segdriver.sv | 28 ++
 rtl/io_hub_v2.sv | 171 +++++++++++++++++
 tb/tb_io_hub_v2.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_hub_pkg.sv
// Shared decode constants for the memory-mapped I/O hub.
// Device ids live in addr[27:24]; register index in addr[7:2].
package io_hub_pkg;

  localparam logic [3:0] IO_SPACE = 4'hF;

  typedef enum logic [3:0] {
    DEV_SEG   = 4'd0,
    DEV_LED   = 4'd1,
    DEV_SW    = 4'd2,
    DEV_KEY   = 4'd3,
    DEV_TIMER = 4'd4
  } dev_e;

  localparam logic [5:0] IDX_ALL      = 6'd63;
  localparam logic [5:0] IDX_KEY_EDGE = 6'd62;
  localparam logic [5:0] IDX_KEY_MASK = 6'd61;

endpackage

// File: rtl/key_debounce.sv
// One push key: 2-flop synchroniser of the inverted key, then a stable-count debouncer.
// press_pulse marks the edge on which the debounced state turns to pressed.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw_n,
  output logic pressed,
  output logic press_pulse
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             meta_q, sync_q, state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             differs, done;

  assign differs = sync_q != state_q;
  assign done    = cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1);

  // Any cycle where the synced key agrees with the accepted state restarts the count.
  always_comb begin
    cnt_d   = '0;
    state_d = state_q;
    if (differs) begin
      if (done) state_d = sync_q;
      else      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  assign pressed     = state_q;
  assign press_pulse = differs & done & sync_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= ~raw_n;
      sync_q  <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/segdriver.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module segdriver (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

// File: rtl/io_hub_v2.sv
// Memory-mapped I/O hub: 7-seg, LED, switch and debounced key devices at addr[31:28]==F.
// Define IO_HUB_TIMER_EN to add the free-running timer device (dev 4).
module io_hub_v2 #(
  parameter int SEG_DIGITS      = 6,
  parameter int LED_WIDTH       = 10,
  parameter int SW_WIDTH        = 10,
  parameter int KEY_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [31:0]             addr,
  input  logic [31:0]             datain,
  input  logic                    we,
  input  logic [31:0]             memout,
  output logic [31:0]             dataout,
  output logic                    wmem,
  output logic [LED_WIDTH-1:0]    LED,
  output logic [7*SEG_DIGITS-1:0] SEG,
  input  logic [SW_WIDTH-1:0]     SW,
  input  logic [KEY_WIDTH-1:0]    KEY,
  output logic                    irq
);
  import io_hub_pkg::*;

  logic                    targetIo, wrIo, unusedBits;
  logic [3:0]              dev;
  logic [5:0]              idx;
  logic [31:0]             ioRead;
  logic [4*SEG_DIGITS-1:0] seg_q, seg_d;
  logic [LED_WIDTH-1:0]    led_q, led_d;
  logic [SW_WIDTH-1:0]     swMeta_q, swSync_q;
  logic [KEY_WIDTH-1:0]    keyPressed, keyPulse;
  logic [KEY_WIDTH-1:0]    keyEdge_q, keyEdge_d, keyMask_q, keyMask_d;

  assign targetIo   = addr[31:28] == IO_SPACE;
  assign dev        = addr[27:24];
  assign idx        = addr[7:2];
  assign wrIo       = we & targetIo;
  assign wmem       = we & ~targetIo;
  assign dataout    = targetIo ? ioRead : memout;
  assign LED        = led_q;
  assign unusedBits = ^{addr[23:8], addr[1:0], datain};

  for (genvar i = 0; i < KEY_WIDTH; i++) begin : gKey
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uKey (
      .clock(clock), .resetn(resetn), .raw_n(KEY[i]),
      .pressed(keyPressed[i]), .press_pulse(keyPulse[i])
    );
  end

  for (genvar i = 0; i < SEG_DIGITS; i++) begin : gSeg
    segdriver uSeg (.hex(seg_q[4*i +: 4]), .seg(SEG[7*i +: 7]));
  end

`ifdef IO_HUB_TIMER_EN
  logic [31:0] timerCnt_q, timerCnt_d, timerCmp_q, timerCmp_d;
  logic        timerFlag_q, timerFlag_d, timerWr;

  assign timerWr = wrIo && (dev == DEV_TIMER);

  // The compare looks at the next count so flag and matching count appear together.
  always_comb begin
    timerCnt_d  = timerCnt_q + 32'd1;
    timerCmp_d  = timerCmp_q;
    timerFlag_d = timerFlag_q;
    if (timerWr && idx == 6'd0) timerCnt_d = datain + 32'd1;
    if (timerWr && idx == 6'd1) timerCmp_d = datain;
    if (timerWr && idx == 6'd2 && datain[0]) timerFlag_d = 1'b0;
    if (timerCnt_d == timerCmp_q) timerFlag_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      timerCnt_q  <= '0;
      timerCmp_q  <= '1;
      timerFlag_q <= 1'b0;
    end else begin
      timerCnt_q  <= timerCnt_d;
      timerCmp_q  <= timerCmp_d;
      timerFlag_q <= timerFlag_d;
    end
  end

  assign irq = (|(keyEdge_q & keyMask_q)) | timerFlag_q;
`else
  assign irq = |(keyEdge_q & keyMask_q);
`endif

  // A fresh press on the same edge as a W1C keeps its EDGE bit set.
  always_comb begin
    seg_d     = seg_q;
    led_d     = led_q;
    keyMask_d = keyMask_q;
    keyEdge_d = keyEdge_q;
    if (wrIo) begin
      case (dev)
        DEV_SEG: begin
          if (idx == IDX_ALL) seg_d = datain[4*SEG_DIGITS-1:0];
          for (int i = 0; i < SEG_DIGITS; i++)
            if (idx == 6'(i)) seg_d[4*i +: 4] = datain[3:0];
        end
        DEV_LED: begin
          if (idx == IDX_ALL) led_d = datain[LED_WIDTH-1:0];
          for (int i = 0; i < LED_WIDTH; i++)
            if (idx == 6'(i)) led_d[i] = datain[0];
        end
        DEV_KEY: begin
          if (idx == IDX_KEY_EDGE) keyEdge_d = keyEdge_q & ~datain[KEY_WIDTH-1:0];
          if (idx == IDX_KEY_MASK) keyMask_d = datain[KEY_WIDTH-1:0];
        end
        default: ;
      endcase
    end
    keyEdge_d = keyEdge_d | keyPulse;
  end

  always_comb begin
    ioRead = '0;
    case (dev)
      DEV_SEG: begin
        if (idx == IDX_ALL) ioRead = 32'(seg_q);
        for (int i = 0; i < SEG_DIGITS; i++)
          if (idx == 6'(i)) ioRead = {28'd0, seg_q[4*i +: 4]};
      end
      DEV_LED: begin
        if (idx == IDX_ALL) ioRead = 32'(led_q);
        for (int i = 0; i < LED_WIDTH; i++)
          if (idx == 6'(i)) ioRead = {31'd0, led_q[i]};
      end
      DEV_SW: begin
        if (idx == IDX_ALL) ioRead = 32'(swSync_q);
        for (int i = 0; i < SW_WIDTH; i++)
          if (idx == 6'(i)) ioRead = {31'd0, swSync_q[i]};
      end
      DEV_KEY: begin
        if (idx == IDX_ALL)      ioRead = 32'(keyPressed);
        if (idx == IDX_KEY_EDGE) ioRead = 32'(keyEdge_q);
        if (idx == IDX_KEY_MASK) ioRead = 32'(keyMask_q);
        for (int i = 0; i < KEY_WIDTH; i++)
          if (idx == 6'(i)) ioRead = {31'd0, keyPressed[i]};
      end
`ifdef IO_HUB_TIMER_EN
      DEV_TIMER: begin
        if (idx == 6'd0) ioRead = timerCnt_q;
        if (idx == 6'd1) ioRead = timerCmp_q;
        if (idx == 6'd2) ioRead = {31'd0, timerFlag_q};
      end
`endif
      default: ioRead = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      seg_q     <= '0;
      led_q     <= '0;
      swMeta_q  <= '0;
      swSync_q  <= '0;
      keyEdge_q <= '0;
      keyMask_q <= '0;
    end else begin
      seg_q     <= seg_d;
      led_q     <= led_d;
      swMeta_q  <= SW;
      swSync_q  <= swMeta_q;
      keyEdge_q <= keyEdge_d;
      keyMask_q <= keyMask_d;
    end
  end
endmodule

// File: tb/tb_io_hub_v2.sv
// Self-checking bench for io_hub_v2: directed steps from the test plan, then a randomized
// phase compared against a cycle-level behavioural model of the hub's register map.
module tb_io_hub_v2;
  localparam int SEG_DIGITS = 6;
  localparam int LED_WIDTH  = 10;
  localparam int SW_WIDTH   = 10;
  localparam int KEY_WIDTH  = 4;
  localparam int DB         = 4;
  localparam logic [31:0] LED_M = 32'((64'd1 << LED_WIDTH) - 1);
  localparam logic [31:0] SW_M  = 32'((64'd1 << SW_WIDTH) - 1);
  localparam logic [31:0] KEY_M = 32'((64'd1 << KEY_WIDTH) - 1);

  logic                    clock = 1'b0;
  logic                    resetn;
  logic [31:0]             addr, datain, memout, dataout;
  logic                    we, wmem, irq;
  logic [LED_WIDTH-1:0]    LED;
  logic [7*SEG_DIGITS-1:0] SEG;
  logic [SW_WIDTH-1:0]     SW;
  logic [KEY_WIDTH-1:0]    KEY;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  io_hub_v2 #(
    .SEG_DIGITS(SEG_DIGITS), .LED_WIDTH(LED_WIDTH), .SW_WIDTH(SW_WIDTH),
    .KEY_WIDTH(KEY_WIDTH), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock), .resetn(resetn), .addr(addr), .datain(datain), .we(we),
    .memout(memout), .dataout(dataout), .wmem(wmem), .LED(LED), .SEG(SEG),
    .SW(SW), .KEY(KEY), .irq(irq)
  );

  // Reference model: register contents plus delay lines and stable-run counts per key.
  int          mSeg[8];
  int          mRun[32];
  logic [31:0] mLed, mPressed, mEdge, mMask, mKeyH0, mKeyH1, mSwH0, mSwH1;
`ifdef IO_HUB_TIMER_EN
  logic [31:0] mCnt, mCmp;
  logic        mFlag;
`endif

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mSeg[i] = 0;
    for (int i = 0; i < 32; i++) mRun[i] = 0;
    mLed = '0; mPressed = '0; mEdge = '0; mMask = '0;
    mKeyH0 = '0; mKeyH1 = '0; mSwH0 = '0; mSwH1 = '0;
`ifdef IO_HUB_TIMER_EN
    mCnt = '0; mCmp = '1; mFlag = 1'b0;
`endif
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelEdge();
    logic [31:0]          w1c, newPress;
    logic [KEY_WIDTH-1:0] kn;
    int                   ix;
    bit                   ioWr;
    w1c = '0; newPress = '0;
    ix = int'(addr[7:2]);
    ioWr = we && (addr[31:28] == 4'hF);
    if (!resetn) begin
      modelReset();
      return;
    end
`ifdef IO_HUB_TIMER_EN
    begin
      logic [31:0] nextCnt, nextCmp;
      bit          tw;
      tw = ioWr && (addr[27:24] == 4'd4);
      nextCnt = (tw && ix == 0) ? datain + 1 : mCnt + 1;
      nextCmp = (tw && ix == 1) ? datain : mCmp;
      if (tw && ix == 2 && datain[0]) mFlag = 1'b0;
      if (nextCnt == mCmp) mFlag = 1'b1;
      mCnt = nextCnt;
      mCmp = nextCmp;
    end
`endif
    if (ioWr) begin
      case (int'(addr[27:24]))
        0: begin
          if (ix == 63) for (int i = 0; i < SEG_DIGITS; i++) mSeg[i] = int'((datain >> (4*i)) & 32'hF);
          else if (ix < SEG_DIGITS) mSeg[ix] = int'(datain[3:0]);
        end
        1: begin
          if (ix == 63) mLed = datain & LED_M;
          else if (ix < LED_WIDTH) mLed[ix] = datain[0];
        end
        3: begin
          if (ix == 62) w1c = datain & KEY_M;
          if (ix == 61) mMask = datain & KEY_M;
        end
        default: ;
      endcase
    end
    for (int k = 0; k < KEY_WIDTH; k++) begin
      if (mKeyH1[k] != mPressed[k]) begin
        mRun[k]++;
        if (mRun[k] == DB) begin
          mPressed[k] = mKeyH1[k];
          mRun[k] = 0;
          if (mKeyH1[k]) newPress[k] = 1'b1;
        end
      end else begin
        mRun[k] = 0;
      end
    end
    mEdge = (mEdge & ~w1c) | newPress;
    kn = ~KEY;
    mKeyH1 = mKeyH0; mKeyH0 = 32'(kn);
    mSwH1 = mSwH0;   mSwH0 = 32'(SW);
  endtask

  function automatic logic [6:0] segPattern(input int n);
    case (n)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;  6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [7*SEG_DIGITS-1:0] expSeg();
    logic [7*SEG_DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < SEG_DIGITS; i++) r[7*i +: 7] = segPattern(mSeg[i]);
    return r;
  endfunction

  function automatic logic expIrq();
`ifdef IO_HUB_TIMER_EN
    return (|(mEdge & mMask)) | mFlag;
`else
    return |(mEdge & mMask);
`endif
  endfunction

  function automatic logic [31:0] expRead(input logic [31:0] a);
    logic [31:0] r;
    int ix;
    r = '0;
    ix = int'(a[7:2]);
    if (a[31:28] != 4'hF) return memout;
    case (int'(a[27:24]))
      0: begin
        if (ix == 63) for (int i = 0; i < SEG_DIGITS; i++) r = r | (32'(mSeg[i]) << (4*i));
        else if (ix < SEG_DIGITS) r = 32'(mSeg[ix]);
      end
      1: begin
        if (ix == 63) r = mLed;
        else if (ix < LED_WIDTH) r = {31'd0, mLed[ix]};
      end
      2: begin
        if (ix == 63) r = mSwH1;
        else if (ix < SW_WIDTH) r = {31'd0, mSwH1[ix]};
      end
      3: begin
        if (ix == 63) r = mPressed;
        else if (ix == 62) r = mEdge;
        else if (ix == 61) r = mMask;
        else if (ix < KEY_WIDTH) r = {31'd0, mPressed[ix]};
      end
`ifdef IO_HUB_TIMER_EN
      4: begin
        if (ix == 0) r = mCnt;
        else if (ix == 1) r = mCmp;
        else if (ix == 2) r = {31'd0, mFlag};
      end
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic w);
    addr = a; datain = d; we = w;
    #1;
  endtask

  task automatic stepClock();
    modelEdge();
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    we = 1'b0;
    repeat (n) stepClock();
  endtask

  task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(a, d, 1'b1);
    stepClock();
    applyStimulus(a, 32'd0, 1'b0);
  endtask

  task automatic readCheck(input string tag, input logic [31:0] a, input logic [31:0] expected);
    applyStimulus(a, 32'd0, 1'b0);
    checkOutput(tag, 64'(dataout), 64'(expected));
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".dataout"}, 64'(dataout), 64'(expRead(addr)));
    checkOutput({tag, ".wmem"}, 64'(wmem), 64'(we && (addr[31:28] != 4'hF)));
    checkOutput({tag, ".led"}, 64'(LED), 64'(mLed));
    checkOutput({tag, ".seg"}, 64'(SEG), 64'(expSeg()));
    checkOutput({tag, ".irq"}, 64'(irq), 64'(expIrq()));
  endtask

  initial begin
    modelReset();
    resetn = 1'b0; addr = '0; datain = '0; we = 1'b0; memout = '0;
    SW = '0; KEY = '1;
    idle(2);
    resetn = 1'b1;
    $display("[TB] reset released");
    applyStimulus(32'h0, 32'h0, 1'b0);
    checkOutput("resetLed", 64'(LED), 64'd0);
    checkOutput("resetSeg", 64'(SEG), 64'({SEG_DIGITS{7'b1000000}}));
    checkOutput("resetIrq", 64'(irq), 64'd0);
    readCheck("resetMask", 32'hF30000F4, 32'd0);

    // Seven-segment digit and packed writes.
    applyStimulus(32'hF0000008, 32'h5, 1'b1);
    checkOutput("segWrWmem", 64'(wmem), 64'd0);
    stepClock();
    readCheck("segDigit2", 32'hF0000008, 32'h5);
    applyStimulus(32'hF00000FC, 32'h00ABCDEF, 1'b1);
    checkOutput("segPackWmem", 64'(wmem), 64'd0);
    stepClock();
    readCheck("segPacked", 32'hF00000FC, 32'h00ABCDEF);
    checkOutput("segDigit0F", 64'(SEG[6:0]), 64'(7'b0001110));

    // LEDs, out-of-range index, memory pass-through.
    writeReg(32'hF1000000, 32'h1);
    checkOutput("ledBit0", 64'(LED), 64'h001);
    writeReg(32'hF10000FC, 32'h3FF);
    checkOutput("ledPacked", 64'(LED), 64'h3FF);
    readCheck("ledIdx10", 32'hF1000028, 32'd0);
    writeReg(32'hF1000028, 32'd0);
    checkOutput("ledIdx10Wr", 64'(LED), 64'h3FF);
    memout = 32'h12345678;
    applyStimulus(32'h00000100, 32'hCAFE, 1'b1);
    checkOutput("memWmem", 64'(wmem), 64'd1);
    checkOutput("memData", 64'(dataout), 64'h12345678);
    stepClock();

    // Short glitch on KEY0 is rejected.
    KEY = 4'hE; idle(3);
    KEY = 4'hF; idle(8);
    readCheck("glitchPressed", 32'hF30000FC, 32'd0);
    readCheck("glitchEdge", 32'hF30000F8, 32'd0);

    // Held KEY0 is accepted after sync plus DB stable cycles.
    KEY = 4'hE; idle(5);
    readCheck("pressEarly", 32'hF3000000, 32'd0);
    idle(1);
    readCheck("pressAccepted", 32'hF3000000, 32'd1);
    readCheck("pressEdge", 32'hF30000F8, 32'd1);
    checkOutput("irqMasked", 64'(irq), 64'd0);
    writeReg(32'hF30000F4, 32'h1);
    checkOutput("irqUnmasked", 64'(irq), 64'd1);

    // Release sets no event; W1C clears; W1C coinciding with a press loses.
    KEY = 4'hF; idle(8);
    readCheck("releasePressed", 32'hF30000FC, 32'd0);
    readCheck("releaseEdge", 32'hF30000F8, 32'd1);
    writeReg(32'hF30000F8, 32'h1);
    readCheck("w1cEdge", 32'hF30000F8, 32'd0);
    checkOutput("w1cIrq", 64'(irq), 64'd0);
    KEY = 4'hE; idle(5);
    writeReg(32'hF30000F8, 32'h1);
    readCheck("setWinsEdge", 32'hF30000F8, 32'd1);
    checkOutput("setWinsIrq", 64'(irq), 64'd1);
    writeReg(32'hF30000F8, 32'h1);
    readCheck("laterW1cEdge", 32'hF30000F8, 32'd0);
    checkOutput("laterW1cIrq", 64'(irq), 64'd0);

    // Switch synchroniser latency and read-only behaviour.
    SW = 10'h2AA;
    readCheck("swOld0", 32'hF20000FC, 32'd0);
    idle(1);
    readCheck("swOld1", 32'hF20000FC, 32'd0);
    idle(1);
    readCheck("swNew", 32'hF20000FC, 32'h2AA);
    readCheck("swBit1", 32'hF2000004, 32'd1);
    writeReg(32'hF20000FC, 32'd0);
    readCheck("swReadOnly", 32'hF20000FC, 32'h2AA);

    // Reset in the middle of a debounce count.
    KEY = 4'hF; idle(8);
    KEY = 4'hE; idle(4);
    resetn = 1'b0; idle(1);
    resetn = 1'b1;
    checkOutput("midRstLed", 64'(LED), 64'd0);
    checkOutput("midRstSeg", 64'(SEG), 64'({SEG_DIGITS{7'b1000000}}));
    readCheck("midRstEdge", 32'hF30000F8, 32'd0);
    readCheck("midRstMask", 32'hF30000F4, 32'd0);
    idle(5);
    readCheck("restartEarly", 32'hF3000000, 32'd0);
    idle(1);
    readCheck("restartPressed", 32'hF3000000, 32'd1);

`ifdef IO_HUB_TIMER_EN
    writeReg(32'hF4000004, 32'd5);
    writeReg(32'hF4000000, 32'hFFFFFFFE);
    readCheck("timerLoad", 32'hF4000000, 32'hFFFFFFFF);
    idle(1);
    readCheck("timerWrap", 32'hF4000000, 32'h0);
    idle(4);
    readCheck("timerFlagEarly", 32'hF4000008, 32'd0);
    idle(1);
    readCheck("timerFlagSet", 32'hF4000008, 32'd1);
    checkOutput("timerIrq", 64'(irq), 64'd1);
    writeReg(32'hF4000008, 32'd1);
    readCheck("timerFlagClr", 32'hF4000008, 32'd0);
`else
    applyStimulus(32'hF4000000, 32'h1234, 1'b1);
    checkOutput("dev4Wmem", 64'(wmem), 64'd0);
    stepClock();
    readCheck("dev4Read", 32'hF4000000, 32'd0);
`endif

    // Randomized traffic against the model.
    $display("[TB] random phase");
    for (int c = 0; c < 300; c++) begin
      logic [31:0] a;
      logic [5:0]  ix;
      logic [3:0]  dv, hi;
      int          op;
      op = int'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) KEY = KEY ^ KEY_WIDTH'(1 << $urandom_range(0, KEY_WIDTH - 1));
      if ($urandom_range(0, 15) == 0) SW = SW_WIDTH'($urandom);
      memout = $urandom;
      ix = 6'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) ix = 6'($urandom_range(61, 63));
      dv = 4'($urandom_range(0, 5));
      a = {4'hF, dv, 16'($urandom), ix, 2'($urandom)};
      if (op == 0) begin
        hi = 4'($urandom_range(0, 14));
        a[31:28] = hi;
      end
      applyStimulus(a, $urandom, (op < 5) ? 1'b1 : 1'b0);
      checkAll("rand");
      stepClock();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
